apb_mem_slave: RTL and testbench

- APB completer that sits directly downstream of the team's APB master and answers its setup/access transfers.
- Holds a word-addressed register/RAM map with a fixed ID word and a read-only transfer counter.
- Inserts a parameterisable number of wait states.
- Flags bad accesses on pslverr.

---
 rtl/apb_mem_slave.sv | 124 ++++++++++++
 tb/tb_apb_mem_slave.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB completer with a word-addressed ID/counter/RAM map.
// Wait states are fixed when the transfer is set up, so pready comes only from state.
module apb_mem_slave #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [32:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // With no wait states the first access cycle is already the completing one.
    localparam logic [1:0] S_START   = (WAIT_STATES == 0) ? S_DONE : S_ACCESS;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0
                                                          : 4'(WAIT_STATES - 1);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic [15:0] xfer_cnt;
    logic [32:0] addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [DEPTH];

    logic        setup;
    logic        take;
    logic [29:0] idx;
    logic        err;
    logic [31:0] rd_word;

    assign setup = psel && !penable;
    assign take  = setup && (state == S_IDLE || state == S_DONE);
    assign idx   = addr_q[31:2];

    assign err = addr_q[32]
              || (addr_q[1:0] != 2'b00)
              || (idx >= DEPTH_W)
              || (write_q && idx < 30'd2);

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            idx == 30'd0: rd_word = ID_VALUE;
            idx == 30'd1: rd_word = {16'h0, xfer_cnt};
            default:      rd_word = mem[idx[AW-1:0]];
        endcase
    end

    assign pready  = (state == S_DONE);
    assign pslverr = pready && err;
    assign prdata  = (pready && !err && !write_q) ? rd_word : '0;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (take) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            xfer_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (setup) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_START;
                    end
                end
                S_ACCESS: begin
                    if (!psel) begin
                        state <= S_IDLE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (xfer_cnt != 16'hFFFF) begin
                        xfer_cnt <= xfer_cnt + 16'd1;
                    end
                    if (setup) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_START;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (state == S_DONE && write_q && !err) begin
            mem[idx[AW-1:0]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: directed table, random traffic vs a map model,
// and hand-driven abort/reset/back-to-back sequences.
module tb_apb_mem_slave;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel0, psel2, penable, pwrite;
    logic [32:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata2;
    logic        pready0, pready2, pslverr0, pslverr2;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    always #5 pclk = ~pclk;

    apb_mem_slave #(.DEPTH(64), .WAIT_STATES(2), .ID_VALUE(ID)) dut (
        .pclk(pclk), .preset(preset), .psel(psel2), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
    );

    apb_mem_slave #(.DEPTH(64), .WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    // Map model, index 0 = zero-wait slave, index 1 = two-wait slave
    logic [31:0] mem_m   [2][64];
    bit          known_m [2][64];
    int          cnt_m   [2];

    typedef struct {
        bit          wr;
        logic [32:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model(input int w, input bit wr, input logic [32:0] a,
                         input logic [31:0] d, output logic [31:0] er,
                         output logic ee, output bit kn);
        longint idx;
        idx = longint'(a[31:2]);
        ee  = a[32] || (a[1:0] != 2'b00) || idx >= 64 || (wr && idx < 2);
        er  = '0;
        kn  = 1'b1;
        if (!ee && !wr) begin
            if (idx == 0)      er = ID;
            else if (idx == 1) er = {16'h0, 16'(cnt_m[w])};
            else begin
                er = mem_m[w][int'(idx)];
                kn = known_m[w][int'(idx)];
            end
        end
        if (!ee && wr) begin
            mem_m[w][int'(idx)]   = d;
            known_m[w][int'(idx)] = 1'b1;
        end
        if (cnt_m[w] < 65535) cnt_m[w]++;
    endtask

    task automatic xfer(input int w, input bit wr, input logic [32:0] a,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rd, output logic er);
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        @(posedge pclk); #1;
        psel0   = (w == 0);
        psel2   = (w == 1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        pwrite  = ~wr;
        paddr   = {1'b0, $urandom};
        pwdata  = $urandom;
        for (int n = 1; n <= 20; n++) begin
            @(negedge pclk);
            if ((w == 1) ? pready2 : pready0) begin
                lat = n;
                rd  = (w == 1) ? prdata2 : prdata0;
                er  = (w == 1) ? pslverr2 : pslverr0;
                break;
            end
            chk("wait_prdata", (w == 1) ? prdata2 : prdata0, 32'h0);
            chk("wait_pslverr", {31'h0, (w == 1) ? pslverr2 : pslverr0}, 32'h0);
            @(posedge pclk); #1;
        end
    endtask

    task automatic run_model(input int w, input bit wr,
                             input logic [32:0] a, input logic [31:0] d);
        logic [31:0] er, rd;
        logic        ee, e;
        bit          kn;
        int          lat;
        model(w, wr, a, d, er, ee, kn);
        xfer(w, wr, a, d, lat, rd, e);
        chk("latency", 32'(lat), (w == 1) ? 32'd3 : 32'd1);
        chk("pslverr", {31'h0, e}, {31'h0, ee});
        if (kn) chk("prdata", rd, er);
    endtask

    task automatic bus_idle();
        @(posedge pclk); #1;
        psel0   = 1'b0;
        psel2   = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        logic [31:0] er;
        logic        ee;
        bit          kn;
        int          lat;

        vecs[0]  = '{1'b1, 33'h008, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 33'h008, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 33'h000, 32'h0,        ID,           1'b0};
        vecs[3]  = '{1'b1, 33'h000, 32'h12345678, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 33'h000, 32'h0,        ID,           1'b0};
        vecs[5]  = '{1'b0, 33'h004, 32'h0,        32'd5,        1'b0};
        vecs[6]  = '{1'b0, 33'h004, 32'h0,        32'd6,        1'b0};
        vecs[7]  = '{1'b0, 33'h006, 32'h0,        32'h0,        1'b1};
        vecs[8]  = '{1'b1, 33'h100, 32'h55AA55AA, 32'h0,        1'b1};
        vecs[9]  = '{1'b1, 33'h004, 32'h00000001, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 33'h100000008, 32'h0,  32'h0,        1'b1};
        vecs[11] = '{1'b1, 33'h0FC, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 33'h0FC, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[13] = '{1'b0, 33'h100, 32'h0,        32'h0,        1'b1};
        vecs[14] = '{1'b0, 33'h008, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[15] = '{1'b0, 33'h004, 32'h0,        32'd15,       1'b0};

        preset  = 1'b1;
        psel0   = 1'b0;
        psel2   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_pready2", {31'h0, pready2}, 32'h0);
        chk("rst_pslverr2", {31'h0, pslverr2}, 32'h0);
        chk("rst_prdata2", prdata2, 32'h0);
        chk("rst_pready0", {31'h0, pready0}, 32'h0);
        @(negedge pclk);
        preset = 1'b0;

        foreach (vecs[i]) begin
            model(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, er, ee, kn);
            xfer(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd, e);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        end
        bus_idle();

        for (int k = 0; k < 150; k++) begin
            int          w, r;
            bit          wr;
            logic [32:0] a;
            w  = int'($urandom_range(1, 0));
            wr = bit'($urandom_range(1, 0));
            r  = int'($urandom_range(9, 0));
            a  = {1'b0, 32'($urandom_range(69, 0)) << 2};
            if (r >= 9)      a = {1'b1, $urandom};
            else if (r >= 7) a = a | 33'($urandom_range(3, 1));
            run_model(w, wr, a, $urandom);
            if (r == 0) bus_idle();
        end
        bus_idle();

        // Master drops psel in the second access cycle of a write
        run_model(1, 1'b1, 33'h10, 32'h11112222);
        bus_idle();
        @(posedge pclk); #1;
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 33'h10; pwdata = 32'h99999999;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        chk("abort_c1", {31'h0, pready2}, 32'h0);
        @(posedge pclk); #1;
        psel2 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge pclk);
            chk("abort_rdy", {31'h0, pready2}, 32'h0);
        end
        penable = 1'b0;
        run_model(1, 1'b0, 33'h10, 32'h0);
        run_model(1, 1'b0, 33'h4, 32'h0);
        bus_idle();

        // Setup for the next write overlaps the completing cycle
        @(posedge pclk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 33'h8; pwdata = 32'h1;
        @(negedge pclk);
        chk("b2b_setup", {31'h0, pready0}, 32'h0);
        @(posedge pclk); #1;
        paddr = 33'hC; pwdata = 32'h2;
        @(negedge pclk);
        chk("b2b_rdy1", {31'h0, pready0}, 32'h1);
        chk("b2b_err1", {31'h0, pslverr0}, 32'h0);
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        chk("b2b_rdy2", {31'h0, pready0}, 32'h1);
        chk("b2b_err2", {31'h0, pslverr0}, 32'h0);
        model(0, 1'b1, 33'h8, 32'h1, er, ee, kn);
        model(0, 1'b1, 33'hC, 32'h2, er, ee, kn);
        bus_idle();
        @(negedge pclk);
        chk("b2b_after", {31'h0, pready0}, 32'h0);
        run_model(0, 1'b0, 33'h8, 32'h0);
        run_model(0, 1'b0, 33'hC, 32'h0);
        bus_idle();

        // Reset while a read is being answered
        run_model(1, 1'b1, 33'h8, 32'h13572468);
        bus_idle();
        @(posedge pclk); #1;
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 33'h8;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("rstd_rdy", {31'h0, pready2}, 32'h1);
        chk("rstd_rd", prdata2, 32'h13572468);
        #1 preset = 1'b1;
        #1;
        chk("rstd_rdy0", {31'h0, pready2}, 32'h0);
        chk("rstd_rd0", prdata2, 32'h0);
        psel2 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset = 1'b0;

        // Reset in the middle of a write's wait cycles
        @(posedge pclk); #1;
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 33'h8; pwdata = 32'h0BAD0BAD;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        #1 preset = 1'b1;
        #1;
        chk("rsta_rdy", {31'h0, pready2}, 32'h0);
        chk("rsta_err", {31'h0, pslverr2}, 32'h0);
        chk("rsta_rd", prdata2, 32'h0);
        psel2 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        run_model(1, 1'b0, 33'h4, 32'h0);
        run_model(1, 1'b0, 33'h8, 32'h0);
        bus_idle();
        repeat (2) @(posedge pclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
